// File: rtl/data_mem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// The burst engine state encoding also lives here.
package data_mem_arb_pkg;

  localparam int DATA_W_DEF   = 24;
  localparam int ADDR_W_DEF   = 24;
  localparam int LEN_W_DEF    = 12;
  localparam int MAX_WAIT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/burst_counter.sv
// Burst address / remaining-word bookkeeping.
// The address wraps modulo 2**ADDR_W.
module burst_counter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] cur_addr_o,
  output logic [LEN_W-1:0]  words_left_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  words_left_q, words_left_d;

  always_comb begin
    cur_addr_d   = cur_addr_q;
    words_left_d = words_left_q;
    if (load_i) begin
      cur_addr_d   = addr_i;
      words_left_d = len_i;
    end else if (step_i && (words_left_q != '0)) begin
      cur_addr_d   = cur_addr_q + ADDR_W'(1);
      words_left_d = words_left_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr_q   <= '0;
      words_left_q <= '0;
    end else begin
      cur_addr_q   <= cur_addr_d;
      words_left_q <= words_left_d;
    end
  end

  assign cur_addr_o   = cur_addr_q;
  assign words_left_o = words_left_q;
  assign last_o       = (words_left_q == LEN_W'(1));

endmodule

// File: rtl/data_mem_arbiter.sv
// Data-memory port arbiter: CPU always wins, a burst engine fills idle cycles.
// The CPU path is purely combinational so the pipeline sees no added latency.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LEN_W    = LEN_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_mem_write,
  input  logic              cpu_mem_read,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              burst_start,
  input  logic              burst_write,
  input  logic [ADDR_W-1:0] burst_addr,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              starve,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  arb_state_e        state_q;
  logic              write_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] ram_adr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [WAIT_W-1:0] wait_cnt_q;

  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  words_left;
  logic              last_word;

  logic cpu_access;
  logic slot_free;
  logic burst_access;
  logic burst_rd;
  logic load;

  // Reset masks the CPU request so every RAM-side output is quiet while rst is low.
  assign cpu_access   = rst & (cpu_mem_write | cpu_mem_read);
  assign slot_free    = (state_q == RUN) & ~cpu_access & (words_left != '0);
  assign burst_access = slot_free & (~write_q | wr_valid);
  assign burst_rd     = burst_access & ~write_q;
  assign load         = (state_q == IDLE) & burst_start & (burst_len != '0);

  burst_counter #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_burst_counter (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .step_i       (burst_access),
    .addr_i       (burst_addr),
    .len_i        (burst_len),
    .cur_addr_o   (cur_addr),
    .words_left_o (words_left),
    .last_o       (last_word)
  );

  always_comb begin
    ram_we    = 1'b0;
    ram_adr   = ram_adr_q;
    ram_wdata = ram_wdata_q;
    if (cpu_access) begin
      ram_we    = cpu_mem_write;
      ram_adr   = cpu_adr;
      ram_wdata = cpu_wdata;
    end else if (burst_access) begin
      ram_we    = write_q;
      ram_adr   = cur_addr;
      if (write_q) begin
        ram_wdata = wr_data;
      end
    end
  end

  assign cpu_rdata = ram_rdata;
  assign wr_ready  = slot_free & write_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign starve    = (wait_cnt_q >= WAIT_W'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      ram_adr_q   <= '0;
      ram_wdata_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      ram_adr_q   <= ram_adr;
      ram_wdata_q <= ram_wdata;
      rd_valid_q  <= burst_rd;
      if (burst_rd) begin
        rd_data_q <= ram_rdata;
      end
      case (state_q)
        IDLE: begin
          wait_cnt_q <= '0;
          if (burst_start) begin
            write_q <= burst_write;
            busy_q  <= 1'b1;
            if (burst_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (burst_access) begin
            wait_cnt_q <= '0;
            if (last_word) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else if (cpu_access && (wait_cnt_q != WAIT_W'(MAX_WAIT))) begin
            // Saturate so starve stays asserted however long the CPU keeps the port.
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        DONE: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          wait_cnt_q <= '0;
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: stimulus pushes predicted port activity,
// a negedge monitor pops and compares against what the DUT presents.
module tb_data_mem_arbiter;

  localparam int DW = 24;
  localparam int AW = 24;
  localparam int LW = 12;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_mem_write = 1'b0;
  logic          cpu_mem_read = 1'b0;
  logic [AW-1:0] cpu_adr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          burst_start = 1'b0;
  logic          burst_write = 1'b0;
  logic [AW-1:0] burst_addr = '0;
  logic [LW-1:0] burst_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;
  logic          starve;
  logic          ram_we;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  data_mem_arbiter #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .LEN_W    (LW),
    .MAX_WAIT (MW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_mem_write (cpu_mem_write),
    .cpu_mem_read  (cpu_mem_read),
    .cpu_adr       (cpu_adr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .burst_start   (burst_start),
    .burst_write   (burst_write),
    .burst_addr    (burst_addr),
    .burst_len     (burst_len),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .busy          (busy),
    .done          (done),
    .starve        (starve),
    .ram_we        (ram_we),
    .ram_adr       (ram_adr),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM: combinational read, synchronous write; 1K words aliased over the address space.
  logic [DW-1:0] ram [0:1023];
  assign ram_rdata = ram[ram_adr[9:0]];
  always @(posedge clk) begin
    if (ram_we) ram[ram_adr[9:0]] <= ram_wdata;
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdata;
    logic          wr_ready;
    logic          busy;
    logic          done;
    logic          starve;
  } port_exp_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } rd_exp_t;

  port_exp_t port_q[$];
  rd_exp_t   rd_q[$];

  int checks = 0;
  int errors = 0;
  int exp_dones = 0;
  int seen_dones = 0;

  // Reference model: a burst is just "next address, words remaining, direction".
  logic [DW-1:0] mdl_mem [0:1023];
  bit            m_active;
  bit            m_wr;
  bit            m_done_now;
  logic [AW-1:0] m_addr;
  logic [AW-1:0] m_last_adr;
  int            m_rem;
  int            m_wait;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_active   = 1'b0;
    m_wr       = 1'b0;
    m_done_now = 1'b0;
    m_addr     = '0;
    m_last_adr = '0;
    m_rem      = 0;
    m_wait     = 0;
  endtask

  // One clock cycle: apply inputs, predict the cycle's port view, advance the model.
  task automatic cyc(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                     input logic bs, input logic bw, input logic [AW-1:0] ba, input logic [LW-1:0] bl,
                     input logic wv, input logic [DW-1:0] wd);
    port_exp_t e;
    rd_exp_t   r;
    bit        cpu;
    bit        slot;
    bit        idle;
    bit        fin;
    @(posedge clk);
    #1;
    cpu_mem_read  = cr;
    cpu_mem_write = cw;
    cpu_adr       = ca;
    cpu_wdata     = cd;
    burst_start   = bs;
    burst_write   = bw;
    burst_addr    = ba;
    burst_len     = bl;
    wr_valid      = wv;
    wr_data       = wd;

    cpu  = cr | cw;
    idle = !m_active && !m_done_now;
    slot = m_active && !cpu && (m_wr ? wv : 1'b1);

    e.busy     = m_active || m_done_now;
    e.done     = m_done_now;
    e.starve   = (m_wait >= MW);
    e.wr_ready = m_active && m_wr && !cpu;
    e.we       = cpu ? cw : (slot && m_wr);
    e.adr      = cpu ? ca : (slot ? m_addr : m_last_adr);
    e.wdata    = cpu ? cd : wd;
    port_q.push_back(e);

    if (slot && !m_wr) begin
      r.data = mdl_mem[m_addr[9:0]];
      r.last = (m_rem == 1);
      rd_q.push_back(r);
    end

    if (e.we) mdl_mem[e.adr[9:0]] = e.wdata;
    if (cpu || slot) m_last_adr = e.adr;

    fin = 1'b0;
    if (slot) begin
      m_addr = m_addr + AW'(1);
      m_rem  = m_rem - 1;
      m_wait = 0;
      if (m_rem == 0) begin
        m_active = 1'b0;
        fin      = 1'b1;
      end
    end else if (m_active && cpu && (m_wait < MW)) begin
      m_wait = m_wait + 1;
    end
    if (!m_active) m_wait = 0;

    if (idle && bs) begin
      if (bl == '0) begin
        fin = 1'b1;
      end else begin
        m_active = 1'b1;
        m_wr     = bw;
        m_addr   = ba;
        m_rem    = int'(bl);
        m_wait   = 0;
      end
    end
    if (fin) exp_dones++;
    m_done_now = fin;
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, 0, 0, '0, '0, 0, '0);
  endtask

  task automatic start(input logic bw, input logic [AW-1:0] ba, input logic [LW-1:0] bl);
    cyc(0, 0, '0, '0, 1, bw, ba, bl, 0, '0);
  endtask

  task automatic cpu_rd(input logic [AW-1:0] a);
    cyc(1, 0, a, '0, 0, 0, '0, '0, 0, '0);
  endtask

  task automatic wr_word(input logic wv, input logic [DW-1:0] d);
    cyc(0, 0, '0, '0, 0, 0, '0, '0, wv, d);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_rd_valid"}, rd_valid, 1'b0);
    chk({tag, "_rd_data"}, rd_data, '0);
    chk({tag, "_starve"}, starve, 1'b0);
    chk({tag, "_wr_ready"}, wr_ready, 1'b0);
    chk({tag, "_ram_we"}, ram_we, 1'b0);
    chk({tag, "_ram_adr"}, ram_adr, '0);
    chk({tag, "_ram_wdata"}, ram_wdata, '0);
  endtask

  // Asynchronous reset asserted between edges, held for n cycles, then released.
  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    rst           = 1'b0;
    cpu_mem_read  = 1'b0;
    cpu_mem_write = 1'b0;
    burst_start   = 1'b0;
    wr_valid      = 1'b0;
    #1;
    check_quiet("async_rst");
    port_q.delete();
    rd_q.delete();
    if (m_done_now) exp_dones--;
    model_clear();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_quiet("rst_hold");
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: one pop per cycle the stimulus predicted, one pop per read-stream word.
  initial begin : monitor
    port_exp_t e;
    rd_exp_t   r;
    forever begin
      @(negedge clk);
      if (port_q.size() > 0) begin
        e = port_q.pop_front();
        chk("ram_we", ram_we, e.we);
        chk("ram_adr", ram_adr, e.adr);
        if (e.we) chk("ram_wdata", ram_wdata, e.wdata);
        chk("wr_ready", wr_ready, e.wr_ready);
        chk("busy", busy, e.busy);
        chk("done", done, e.done);
        chk("starve", starve, e.starve);
        chk("cpu_rdata", cpu_rdata, ram_rdata);
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          chk("rd_valid_unexpected", rd_valid, 1'b0);
        end else begin
          r = rd_q.pop_front();
          chk("rd_data", rd_data, r.data);
          if (r.last) chk("done_with_last_rd", done, 1'b1);
        end
      end
      if (done) seen_dones++;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic          cr, cw, bs, bw, wv;
    logic [LW-1:0] bl;
    int            k;

    for (int i = 0; i < 1024; i++) begin
      ram[i]     = DW'(i * 37) ^ 24'hA5C3E1;
      mdl_mem[i] = DW'(i * 37) ^ 24'hA5C3E1;
    end
    model_clear();

    repeat (3) @(negedge clk);
    check_quiet("por");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Read burst with the CPU idle.
    start(0, 24'h000010, 12'd4);
    idle_cyc(6);

    // CPU load collides with the second burst word.
    start(0, 24'h000010, 12'd4);
    idle_cyc(1);
    cpu_rd(24'h000200);
    idle_cyc(6);

    // Write burst with a two-cycle stream gap.
    start(1, 24'h000040, 12'd3);
    wr_word(1, 24'h111111);
    wr_word(0, 24'h0);
    wr_word(0, 24'h0);
    wr_word(1, 24'h222222);
    wr_word(1, 24'h333333);
    idle_cyc(3);

    // Starvation: CPU owns the port for 20 cycles mid-burst.
    start(0, 24'h000080, 12'd3);
    for (int i = 0; i < 20; i++) cpu_rd(AW'(24'h300 + i));
    idle_cyc(6);

    // Address wrap, read and write.
    start(0, 24'hFFFFFF, 12'd2);
    idle_cyc(4);
    start(1, 24'hFFFFFF, 12'd2);
    wr_word(1, 24'hABCDEF);
    wr_word(1, 24'h123456);
    idle_cyc(3);

    // Zero-length burst.
    start(0, 24'h000500, 12'd0);
    idle_cyc(3);

    // burst_start while RUN and while DONE is ignored.
    start(0, 24'h000020, 12'd3);
    start(1, 24'h000700, 12'd5);
    start(0, 24'h000700, 12'd5);
    start(0, 24'h000700, 12'd5);
    start(1, 24'h000700, 12'd1);
    idle_cyc(4);

    // Reset mid-burst aborts it with no done pulse.
    start(0, 24'h000030, 12'd8);
    idle_cyc(2);
    do_reset(3);
    idle_cyc(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cr = 1'b0;
      cw = 1'b0;
      k  = int'($urandom_range(0, 99));
      if (k < 25) cr = 1'b1;
      else if (k < 40) cw = 1'b1;
      bs = ($urandom_range(0, 7) == 0);
      bw = 1'($urandom_range(0, 1));
      bl = LW'($urandom_range(0, 7));
      wv = ($urandom_range(0, 3) != 0);
      cyc(cr, cw, AW'($urandom), DW'($urandom), bs, bw, AW'($urandom), bl, wv, DW'($urandom));
    end
    idle_cyc(12);

    repeat (4) @(negedge clk);
    chk("rd_queue_drained", 64'(rd_q.size()), 64'd0);
    chk("done_count", 64'(seen_dones), 64'(exp_dones));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
